param_power_unit: RTL and testbench
===================================

Name: param_power_unit

Overview:
- Parametrised exponentiation engine: computes base^exp on a WIDTH-bit unsigned base and an EXP_WIDTH-bit exponent.
- Self-contained datapath. Each multiply is an internal shift-add loop instead of an external ALU/register-file sequence.
- Adds wrap/saturate modes, an overflow flag and a done pulse.
- Sits as a coprocessor behind the top-level controller, driven by a start/busy/done handshake.

Parameters:
- WIDTH, 8, bit width of base and result.
- EXP_WIDTH, 8, bit width of the exponent and of the remaining-multiplications counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- base  input  WIDTH  unsigned base; captured when start is accepted.
- exp  input  EXP_WIDTH  unsigned exponent; captured when start is accepted.
- sat_mode  input  1  captured at start; 1 = saturate on overflow, 0 = wrap modulo 2^WIDTH.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse; result and ovf are valid in that cycle.
- result  output  WIDTH  final value; held until the next accepted start.
- ovf  output  1  sticky overflow for the current operation; held with result.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, result=0, ovf=0, all internal registers cleared. Reset mid-operation aborts immediately with no done pulse.
- Cycle numbering: cycle 0 is the edge where start=1 is sampled in IDLE. At that edge base, exp and sat_mode are captured, acc=1, cnt=exp, ovf cleared, busy<=1.
- start while busy is ignored, and inputs are not recaptured.
- States:
  - IDLE: wait for start.
  - CHECK (1 cycle):
    - exp==0 -> DONE with acc=1 (0^0 defined as 1).
    - base==0 -> DONE with acc=0.
    - base==1 -> DONE with acc=1.
    - otherwise -> MUL_STEP.
  - MUL_STEP (exactly WIDTH cycles): shift-add of acc*base into a 2*WIDTH-bit product. One multiplier bit per cycle, LSB first.
  - MUL_DONE (1 cycle):
    - cnt decrements by 1.
    - If the upper WIDTH bits of the product are nonzero, ovf<=1.
    - sat_mode=1 and overflow: acc<=all ones -> DONE (early exit).
    - Otherwise acc<=low WIDTH bits of the product; cnt!=0 -> MUL_STEP, cnt==0 -> DONE.
  - DONE (1 cycle): result<=acc, done=1, busy=0 -> IDLE.
- Latency: done is high in cycle 2 for the CHECK shortcuts. In the general case it is high in cycle 2 + exp*(WIDTH+1); saturating early exit shortens this.
- busy is high from cycle 1 until the cycle before done; busy and done are never both high.
- Wrap mode: ovf stays set once any intermediate product overflows; result is the true value mod 2^WIDTH.
- A start sampled in the same cycle as done is ignored; the state is still DONE.
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
- Macro: PARAM_POWER_UNIT_CYCLE_COUNT_EN.
- Defined: adds output port cycles [15:0]. The counter clears at start acceptance, increments every busy cycle, saturates at 16'hFFFF, is frozen at done and resets to 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package power_unit_pkg holds:
  - state encoding localparams IDLE, CHECK, MUL_STEP, MUL_DONE, DONE (3-bit);
  - the DONE-pulse width constant.
- One sub-module is natural: shift_add_multiplier (WIDTH-parametrised, load/step/ready, 2*WIDTH-bit product). The power unit instantiates it once; it owns the bit counter for MUL_STEP.

Test Plan:
- WIDTH=8, base=3, exp=4, sat_mode=0 -> result=81, ovf=0, done in cycle 38, busy high in cycles 1..37.
- base=2, exp=9, sat_mode=0 -> result=0, ovf=1, done in cycle 83.
- base=2, exp=9, sat_mode=1 -> result=255, ovf=1, done in cycle 74 (early exit after the 8th multiply).
- Shortcuts, each with done in cycle 2 and ovf=0:
  - base=0, exp=0 -> result=1;
  - base=5, exp=0 -> result=1;
  - base=1, exp=200 -> result=1;
  - base=0, exp=7 -> result=0.
- During a base=3, exp=4 run:
  - pulse start with base=2, exp=2 in cycle 10 -> ignored, result=81;
  - then drive rst_n low in cycle 20 of a new run -> busy=0, result=0, ovf=0 immediately, no done pulse;
  - after release, a fresh start runs normally.
- Back-to-back: start held high continuously -> new operation accepted in the cycle after done; result from the previous run stays visible until the new done.

Source files
------------

// File: rtl/power_unit_pkg.sv
// Shared definitions for param_power_unit: FSM state encoding and the done-pulse width.
package power_unit_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    MUL_STEP = 3'd2,
    MUL_DONE = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam int unsigned DonePulseCycles = 1;

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential WIDTH x WIDTH shift-add multiplier, one multiplier bit per step, LSB first.
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  always_comb begin
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      prod_d   = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
    end
  end

  // High during the step that consumes the last multiplier bit.
  assign ready_o   = (cnt_q == CntW'(WIDTH - 1));
  assign product_o = prod_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/param_power_unit.sv
// Sequential base^exp engine with wrap/saturate modes, sticky overflow and a done pulse.
// Optional busy-cycle counter output enabled by PARAM_POWER_UNIT_CYCLE_COUNT_EN.
module param_power_unit
  import power_unit_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EXP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic                 sat_mode,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
`ifdef PARAM_POWER_UNIT_CYCLE_COUNT_EN
  output logic [15:0]          cycles,
`endif
  output logic                 ovf
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     base_q, base_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [EXP_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 mul_load, mul_step, mul_ready, prod_hi;
  logic [WIDTH-1:0]     mul_a;
  logic [2*WIDTH-1:0]   product;

  shift_add_multiplier #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .load_i    (mul_load),
    .step_i    (mul_step),
    .a_i       (mul_a),
    .b_i       (base_q),
    .ready_o   (mul_ready),
    .product_o (product)
  );

  assign prod_hi = |product[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    mul_a    = acc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base;
          sat_d   = sat_mode;
          cnt_d   = exp;
          acc_d   = WIDTH'(1);
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // x^0 = 1 (including 0^0); 0^n and 1^n need no multiplies.
        if (cnt_q == '0) begin
          acc_d   = WIDTH'(1);
          state_d = DONE;
        end else if (base_q == '0) begin
          acc_d   = '0;
          state_d = DONE;
        end else if (base_q == WIDTH'(1)) begin
          acc_d   = WIDTH'(1);
          state_d = DONE;
        end else begin
          mul_load = 1'b1;
          state_d  = MUL_STEP;
        end
      end
      MUL_STEP: begin
        mul_step = 1'b1;
        if (mul_ready) begin
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        cnt_d = cnt_q - EXP_WIDTH'(1);
        if (prod_hi) begin
          ovf_d = 1'b1;
        end
        if (sat_q && prod_hi) begin
          acc_d   = '1;
          state_d = DONE;
        end else begin
          acc_d = product[WIDTH-1:0];
          if (cnt_d != '0) begin
            mul_a    = acc_d;
            mul_load = 1'b1;
            state_d  = MUL_STEP;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are registered on entry to DONE so result/ovf/done line up in the DONE cycle.
    if (state_q != DONE && state_d == DONE) begin
      result_d = acc_d;
      done_d   = 1'b1;
      busy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

`ifdef PARAM_POWER_UNIT_CYCLE_COUNT_EN
  logic [15:0] cycles_q, cycles_d;

  always_comb begin
    cycles_d = cycles_q;
    if (state_q == IDLE && start) begin
      cycles_d = '0;
    end else if (busy_q && cycles_q != 16'hFFFF) begin
      cycles_d = cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_param_power_unit.sv
// Self-checking bench for param_power_unit: directed table, multi-cycle corner sequences and
// randomized operations against an arithmetic reference model.
module tb_param_power_unit;

  localparam int unsigned W  = 8;
  localparam int unsigned EW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  base;
  logic [EW-1:0] exp_in;
  logic          sat_mode;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          ovf;
`ifdef PARAM_POWER_UNIT_CYCLE_COUNT_EN
  logic [15:0]   cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_power_unit #(
    .WIDTH     (W),
    .EXP_WIDTH (EW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base     (base),
    .exp      (exp_in),
    .sat_mode (sat_mode),
    .busy     (busy),
    .done     (done),
    .result   (result),
`ifdef PARAM_POWER_UNIT_CYCLE_COUNT_EN
    .cycles   (cycles),
`endif
    .ovf      (ovf)
  );

  typedef struct {
    int b;
    int e;
    bit sat;
    int res;
    bit ov;
    int lat;
  } vec_t;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Reference: true power with first-overflow exponent; wrap result via modular power.
  task automatic model(input int b, input int e, input bit sat,
                       output int res, output bit ov, output int lat);
    longint p;
    int     k_ovf;
    int     r;
    p     = 1;
    k_ovf = 0;
    if (e == 0 || b <= 1) begin
      res = (e == 0) ? 1 : b;
      ov  = 1'b0;
      lat = 2;
      return;
    end
    for (int k = 1; k <= e; k++) begin
      p = p * b;
      if (p >= 256) begin
        k_ovf = k;
        break;
      end
    end
    r = 1;
    for (int k = 0; k < e; k++) r = (r * b) % 256;
    if (k_ovf == 0) begin
      res = int'(p);
      ov  = 1'b0;
      lat = 2 + e * (W + 1);
    end else if (sat) begin
      res = 255;
      ov  = 1'b1;
      lat = 2 + k_ovf * (W + 1);
    end else begin
      res = r;
      ov  = 1'b1;
      lat = 2 + e * (W + 1);
    end
  endtask

  // Starts an operation from IDLE; cycle k is observed on the negedge before edge k.
  task automatic run_op(input int b, input int e, input bit sat, input int inj,
                        output int res, output bit ov, output int lat, output int busy_cnt,
                        output bit overlap, output bit pulse_ok, output int cyc);
    @(negedge clk);
    start    = 1'b1;
    base     = W'(b);
    exp_in   = EW'(e);
    sat_mode = sat;
    lat      = -1;
    busy_cnt = 0;
    overlap  = 1'b0;
    res      = 0;
    ov       = 1'b0;
    cyc      = 0;
    pulse_ok = 1'b0;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (inj > 0 && k == inj) begin
        start  = 1'b1;
        base   = W'(2);
        exp_in = EW'(2);
      end
      if (inj > 0 && k == inj + 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        lat = k;
        res = int'(result);
        ov  = ovf;
`ifdef PARAM_POWER_UNIT_CYCLE_COUNT_EN
        cyc = int'(cycles);
`endif
        break;
      end
    end
    start = 1'b0;
    if (lat > 0) begin
      @(negedge clk);
      pulse_ok = !done && !busy;
    end
  endtask

  task automatic run_and_check(input string tag, input int b, input int e, input bit sat,
                               input int inj, input int w_res, input bit w_ov, input int w_lat);
    int res, lat, busy_cnt, cyc;
    bit ov, overlap, pulse_ok;
    run_op(b, e, sat, inj, res, ov, lat, busy_cnt, overlap, pulse_ok, cyc);
    check({tag, " latency"}, lat, w_lat);
    check({tag, " result"}, res, w_res);
    check({tag, " ovf"}, ov, w_ov);
    check({tag, " busy cycles"}, busy_cnt, w_lat - 1);
    check({tag, " busy&done overlap"}, overlap, 0);
    check({tag, " single done pulse"}, pulse_ok, 1);
`ifdef PARAM_POWER_UNIT_CYCLE_COUNT_EN
    check({tag, " cycle count"}, cyc, w_lat - 1);
`endif
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    int   m_res, m_lat, d1, d2, b, e;
    bit   m_ov, keep_ok, b30, b31, sat, saw_done;

    rst_n    = 1'b0;
    start    = 1'b0;
    base     = '0;
    exp_in   = '0;
    sat_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset ovf", ovf, 0);
    rst_n = 1'b1;

    vecs.push_back('{3, 4, 1'b0, 81, 1'b0, 38});
    vecs.push_back('{2, 9, 1'b0, 0, 1'b1, 83});
    vecs.push_back('{2, 9, 1'b1, 255, 1'b1, 74});
    vecs.push_back('{0, 0, 1'b0, 1, 1'b0, 2});
    vecs.push_back('{5, 0, 1'b0, 1, 1'b0, 2});
    vecs.push_back('{1, 200, 1'b0, 1, 1'b0, 2});
    vecs.push_back('{0, 7, 1'b0, 0, 1'b0, 2});
    vecs.push_back('{2, 8, 1'b0, 0, 1'b1, 74});
    vecs.push_back('{16, 2, 1'b1, 255, 1'b1, 20});
    vecs.push_back('{255, 1, 1'b1, 255, 1'b0, 11});
    vecs.push_back('{3, 5, 1'b0, 243, 1'b0, 47});
    foreach (vecs[i]) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].b, vecs[i].e, vecs[i].sat, 0,
                    vecs[i].res, vecs[i].ov, vecs[i].lat);
    end

    // Start pulsed mid-operation must neither restart nor recapture.
    run_and_check("ignored start", 3, 4, 1'b0, 10, 81, 1'b0, 38);

    // Reset in cycle 20 of a run aborts at once with no done pulse.
    @(negedge clk);
    start    = 1'b1;
    base     = W'(3);
    exp_in   = EW'(4);
    sat_mode = 1'b0;
    saw_done = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort result", result, 0);
    check("abort ovf", ovf, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort no done", saw_done, 0);
    rst_n = 1'b1;
    run_and_check("after reset", 3, 4, 1'b0, 0, 81, 1'b0, 38);

    // Back-to-back with start held high; previous result stays until the next done.
    @(negedge clk);
    start    = 1'b1;
    base     = W'(2);
    exp_in   = EW'(3);
    sat_mode = 1'b0;
    d1       = -1;
    d2       = -1;
    keep_ok  = 1'b1;
    b30      = 1'b1;
    b31      = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1) begin
        base   = W'(3);
        exp_in = EW'(2);
      end
      if (k == 30) b30 = busy;
      if (k == 31) b31 = busy;
      if (done && d1 < 0) begin
        d1 = k;
        check("b2b first result", result, 8);
      end else if (done && d1 > 0) begin
        d2 = k;
        start = 1'b0;
        check("b2b second result", result, 9);
        break;
      end
      if (d1 < 0) begin
        if (result !== 8'd81) keep_ok = 1'b0;
      end else if (result !== 8'd8) begin
        keep_ok = 1'b0;
      end
    end
    start = 1'b0;
    @(negedge clk);
    check("b2b first done cycle", d1, 29);
    check("b2b second done cycle", d2, 50);
    check("b2b idle gap busy", b30, 0);
    check("b2b reaccept busy", b31, 1);
    check("b2b result held", keep_ok, 1);

    for (int i = 0; i < 40; i++) begin
      b   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 255));
      e   = int'($urandom_range(0, 20));
      sat = 1'($urandom_range(0, 1));
      model(b, e, sat, m_res, m_ov, m_lat);
      run_and_check($sformatf("rand%0d b=%0d e=%0d s=%0d", i, b, e, sat), b, e, sat, 0,
                    m_res, m_ov, m_lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
